expr_eval: RTL and testbench
============================

# expr_eval

Arithmetic evaluator for the expression character stream: one ASCII character per clock, grammar `digit (op digit)*` with single-digit operands `'0'..'9'` and operators `'+'`, `'*'`.
- Sits directly downstream of the expression-recognizer stage and consumes the same `in` byte stream.
- Tracks syntactic validity with the same acceptance rule as that stage.
- Also computes the running value with `*` binding tighter than `+`, so the datapath can use the result without re-parsing.

## Interface
Parameters:
- `WIDTH`, 32: width of the result and internal accumulators; all arithmetic is modulo 2^WIDTH.

Ports:
- `clk` input 1: clock. Everything is sampled on the rising edge.
- `clr` input 1: reset, **asynchronous, active-low**.
- `in` input 8: ASCII character, one consumed every rising edge; there is no valid strobe.
- `ok` output 1: 1 when the characters consumed so far form a complete valid expression.
- `err` output 1: sticky syntax error.
- `result` output WIDTH: value of the expression consumed so far. Meaningful when `ok`=1.
- `ovf` output 1: sticky arithmetic overflow. Present only with `EXPR_EVAL_OVF_EN`.

## Operation
- Character classes:
  - DIGIT: `8'h30..8'h39`, value `in-8'h30`.
  - ADD: `8'h2B`.
  - MUL: `8'h2A`.
  - Anything else is BAD.
- State machine (encoded 2 bits):
  - S_NUM (expecting digit):
    - DIGIT → S_OP.
    - ADD, MUL or BAD → S_ERR.
  - S_OP (after digit):
    - ADD or MUL → S_NUM.
    - DIGIT (multi-digit operand) or BAD → S_ERR.
  - S_ERR is absorbing and is left only by reset.
- Datapath registers: `sum` (WIDTH), `term` (WIDTH), `mul_pend` (1).
  - DIGIT accepted in S_NUM:
    - `term <= mul_pend ? term*d : d` (product truncated to WIDTH).
    - `result <= sum + term_next` (truncated).
  - ADD accepted in S_OP: `sum <= sum + term`, `term <= 0`, `mul_pend <= 0`.
  - MUL accepted in S_OP: `mul_pend <= 1`; `sum` and `term` unchanged.
  - Transition to S_ERR: all datapath registers hold their last values.
- Outputs:
  - `ok` = (state == S_OP).
  - `err` = (state == S_ERR).
  - `result` is a register. It holds its value across operator cycles, so after a trailing operator it still shows the last complete prefix while `ok`=0.

## Timing
- Reset values: state=S_NUM, `sum`=`term`=`result`=0, `mul_pend`=0, `ok`=0, `err`=0, `ovf`=0.
- Reset is asynchronous. Asserting `clr` mid-expression clears every register immediately, independent of `clk`.
- After `clr` is released, the first rising edge consumes the first character.
- Latency is 1 cycle: the character sampled at edge N is reflected in `ok`, `err`, `result` and `ovf` right after edge N.
- All outputs are registered; there are no combinational paths from `in`.
- Throughput: one character per cycle, no stalls, no backpressure.

## Configuration
- `EXPR_EVAL_OVF_EN` defined:
  - The `ovf` port exists.
  - `ovf` sets when any accepted step's untruncated product `term*d` or sum `sum+term` is ≥ 2^WIDTH.
  - Once set, `ovf` stays set until reset.
  - It is unaffected by entry into S_ERR.
- `EXPR_EVAL_OVF_EN` undefined:
  - The port and its logic are absent.
  - Results wrap silently.

## Structure
- Package `expr_pkg`:
  - State typedef `expr_state_t` (S_NUM, S_OP, S_ERR).
  - Character constants `CH_ADD`, `CH_MUL`, `CH_ZERO`, `CH_NINE`.
  - Class typedef `expr_cls_t` (DIGIT, ADD, MUL, BAD).
- Sub-module `expr_char_class`: combinational.
  - Input `in[7:0]`.
  - Outputs the class and digit value `[3:0]`.
  - Reusable by the recognizer stage.

## Test plan
- Reset, then `"1+2*3"` one char per cycle → after the `'3'` edge: `ok`=1, `result`=7, `err`=0. After `'+'` and `'*'` edges, `ok`=0.
- `"1+2*3+456"` → after `'4'`: `ok`=1, `result`=11. After `'5'`: `err`=1, `ok`=0, `result` still 11. `'6'`, `'+'` and further chars leave `err`=1.
- `"2*3*4+5"` → `result` after each digit edge is 2, 6, 24, 29.
- `WIDTH`=4, `"9*9+9"`:
  - After `'9'`, `'9'`: `result`=1 (81 mod 16). With `EXPR_EVAL_OVF_EN`, `ovf`=1.
  - After the final `'9'`: `result`=10.
- Leading `'+'` → `err`=1 after the first edge. Assert `clr` low mid-cycle → `err`, `ok`, `result` and `ovf` clear before the next edge. Then `"7"` → `ok`=1, `result`=7.
- Non-grammar byte `"a"` after `"3"` → `err`=1. `result` holds 3.

Source files
------------

// File: rtl/expr_pkg.sv
// expr_pkg: shared states, character constants and character classes for the expression stages
package expr_pkg;
  typedef enum logic [1:0] {S_NUM, S_OP, S_ERR} expr_state_t;
  typedef enum logic [1:0] {DIGIT, ADD, MUL, BAD} expr_cls_t;
  localparam logic [7:0] CH_ADD  = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NINE = 8'h39;
endpackage

// File: rtl/expr_eval_if.sv
// expr_eval_if: character stream in, validity and value out; ovf exists only with EXPR_EVAL_OVF_EN
interface expr_eval_if #(parameter int WIDTH = 32);
  logic [7:0] in;
  logic ok;
  logic err;
  logic [WIDTH-1:0] result;
`ifdef EXPR_EVAL_OVF_EN
  logic ovf;
  modport master(output in, input ok, err, result, ovf);
  modport slave(input in, output ok, err, result, ovf);
`else
  modport master(output in, input ok, err, result);
  modport slave(input in, output ok, err, result);
`endif
endinterface

// File: rtl/expr_char_class.sv
// expr_char_class: classifies one ASCII byte as digit/add/mul/bad and extracts the digit value
module expr_char_class import expr_pkg::*; (
  input  logic [7:0] in,
  output expr_cls_t  cls,
  output logic [3:0] val
);
  logic [7:0] off;
  assign off = in - CH_ZERO;
  assign cls = (in >= CH_ZERO && in <= CH_NINE) ? DIGIT :
               in == CH_ADD ? ADD :
               in == CH_MUL ? MUL : BAD;
  assign val = off[3:0];
endmodule

// File: rtl/expr_eval.sv
// expr_eval: validates `digit (op digit)*` and evaluates it with * over +, one char per clock
// Optional sticky overflow flag enabled by EXPR_EVAL_OVF_EN.
module expr_eval import expr_pkg::*; #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       clr,
  expr_eval_if.slave bus
);
  expr_cls_t        cls;
  logic [3:0]       val;
  expr_state_t      state, nxt;
  logic [WIDTH-1:0] sum, term, term_nxt, res_r;
  logic             mul_pend, ok_r, err_r, dig_acc, add_acc, mul_acc;
  logic [WIDTH+3:0] prod_w;
  logic [WIDTH:0]   add_w;
  expr_char_class u_cls (.in(bus.in), .cls(cls), .val(val));
  assign dig_acc  = state == S_NUM && cls == DIGIT;
  assign add_acc  = state == S_OP && cls == ADD;
  assign mul_acc  = state == S_OP && cls == MUL;
  assign nxt      = state == S_NUM ? (cls == DIGIT ? S_OP : S_ERR) :
                    state == S_OP  ? ((cls == ADD || cls == MUL) ? S_NUM : S_ERR) : S_ERR;
  // Full-width product and sum keep the carry-out for overflow detection.
  assign prod_w   = {4'b0, term} * {{WIDTH{1'b0}}, val};
  assign add_w    = {1'b0, sum} + {1'b0, term};
  assign term_nxt = mul_pend ? prod_w[WIDTH-1:0] : {{(WIDTH-4){1'b0}}, val};
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state    <= S_NUM;
      sum      <= '0;
      term     <= '0;
      mul_pend <= 1'b0;
      res_r    <= '0;
      ok_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state <= nxt;
      ok_r  <= nxt == S_OP;
      err_r <= nxt == S_ERR;
      if (dig_acc) begin
        term  <= term_nxt;
        res_r <= sum + term_nxt;
      end
      if (add_acc) begin
        sum      <= add_w[WIDTH-1:0];
        term     <= '0;
        mul_pend <= 1'b0;
      end
      if (mul_acc) mul_pend <= 1'b1;
    end
  assign bus.ok     = ok_r;
  assign bus.err    = err_r;
  assign bus.result = res_r;
`ifdef EXPR_EVAL_OVF_EN
  logic ovf_r;
  always_ff @(posedge clk or negedge clr)
    if (!clr) ovf_r <= 1'b0;
    else if ((dig_acc && mul_pend && |prod_w[WIDTH+3:WIDTH]) || (add_acc && add_w[WIDTH])) ovf_r <= 1'b1;
  assign bus.ovf = ovf_r;
`else
  logic unused_carry;
  assign unused_carry = ^{prod_w[WIDTH+3:WIDTH], add_w[WIDTH]};
`endif
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: scoreboard bench for expr_eval at WIDTH=32 and WIDTH=4
module tb_expr_eval;
  typedef struct {
    logic        ok;
    logic        err;
    logic        ovf;
    logic [31:0] res;
    string       tag;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b1;
  exp_t q32[$];
  exp_t q4[$];
  int checks = 0;
  int fails = 0;
  expr_eval_if #(.WIDTH(32)) b32();
  expr_eval_if #(.WIDTH(4))  b4();
  expr_eval #(.WIDTH(32)) d32 (.clk(clk), .clr(clr), .bus(b32));
  expr_eval #(.WIDTH(4))  d4  (.clk(clk), .clr(clr), .bus(b4));
  always #5 clk = ~clk;
  task automatic cmp(string tag, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %0d expected %0d", tag, f, act, exp);
    end
  endtask
  function automatic exp_t mk(string tag, logic ok, logic err, logic [31:0] res, logic ovf);
    exp_t e;
    e.tag = tag; e.ok = ok; e.err = err; e.res = res; e.ovf = ovf;
    return e;
  endfunction
  always @(posedge clk or negedge clr) begin
    exp_t e;
    #1;
    if (q32.size() != 0) begin
      e = q32.pop_front();
      cmp(e.tag, "ok", 32'(b32.ok), 32'(e.ok));
      cmp(e.tag, "err", 32'(b32.err), 32'(e.err));
      cmp(e.tag, "result", b32.result, e.res);
`ifdef EXPR_EVAL_OVF_EN
      cmp(e.tag, "ovf", 32'(b32.ovf), 32'(e.ovf));
`endif
    end
  end
  always @(posedge clk or negedge clr) begin
    exp_t e;
    #1;
    if (q4.size() != 0) begin
      e = q4.pop_front();
      cmp(e.tag, "ok", 32'(b4.ok), 32'(e.ok));
      cmp(e.tag, "err", 32'(b4.err), 32'(e.err));
      cmp(e.tag, "result", 32'(b4.result), e.res);
`ifdef EXPR_EVAL_OVF_EN
      cmp(e.tag, "ovf", 32'(b4.ovf), 32'(e.ovf));
`endif
    end
  end
  task automatic step32(string tag, byte c, logic ok, logic err, logic [31:0] res);
    b32.in = c;
    q32.push_back(mk(tag, ok, err, res, 1'b0));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic step4(string tag, byte c, logic ok, logic err, logic [31:0] res, logic ovf);
    b4.in = c;
    q4.push_back(mk(tag, ok, err, res, ovf));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pulse_clr(string tag);
    q32.push_back(mk(tag, 1'b0, 1'b0, 0, 1'b0));
    q4.push_back(mk(tag, 1'b0, 1'b0, 0, 1'b0));
    #2 clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask
  initial begin
    b32.in = "0";
    b4.in = "0";
    @(negedge clk);
    pulse_clr("reset");
    step32("t1_1", "1", 1, 0, 1);
    step32("t1_plus", "+", 0, 0, 1);
    step32("t1_2", "2", 1, 0, 3);
    step32("t1_mul", "*", 0, 0, 3);
    step32("t1_3", "3", 1, 0, 7);
    pulse_clr("clr2");
    step32("t2_1", "1", 1, 0, 1);
    step32("t2_p", "+", 0, 0, 1);
    step32("t2_2", "2", 1, 0, 3);
    step32("t2_m", "*", 0, 0, 3);
    step32("t2_3", "3", 1, 0, 7);
    step32("t2_p2", "+", 0, 0, 7);
    step32("t2_4", "4", 1, 0, 11);
    step32("t2_5", "5", 0, 1, 11);
    step32("t2_6", "6", 0, 1, 11);
    step32("t2_p3", "+", 0, 1, 11);
    step32("t2_7", "7", 0, 1, 11);
    pulse_clr("clr3");
    step32("t3_2", "2", 1, 0, 2);
    step32("t3_m1", "*", 0, 0, 2);
    step32("t3_3", "3", 1, 0, 6);
    step32("t3_m2", "*", 0, 0, 6);
    step32("t3_4", "4", 1, 0, 24);
    step32("t3_p", "+", 0, 0, 24);
    step32("t3_5", "5", 1, 0, 29);
    pulse_clr("clr4");
    step4("w4_9a", "9", 1, 0, 9, 0);
    step4("w4_m", "*", 0, 0, 9, 0);
    step4("w4_9b", "9", 1, 0, 1, 1);
    step4("w4_p", "+", 0, 0, 1, 1);
    step4("w4_9c", "9", 1, 0, 10, 1);
    step4("w4_bad", "x", 0, 1, 10, 1);
    pulse_clr("clr5");
    step32("lead_plus", "+", 0, 1, 0);
    pulse_clr("async_clr");
    step32("after_clr_7", "7", 1, 0, 7);
    pulse_clr("clr6");
    step32("bad_3", "3", 1, 0, 3);
    step32("bad_a", "a", 0, 1, 3);
    step32("bad_hold", "5", 0, 1, 3);
    repeat (3) @(negedge clk);
    if (q32.size() != 0 || q4.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q32.size(), q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
